pe_west_rx: RTL

- Receiver endpoint for a west-side mesh link into a PE tile.
- Captures link words from in_from_west and buffers them in a small FIFO.
- Presents buffered words as a valid/ready stream to the tile's compute logic.
- Returns flow-control credits to the upstream transmitter on out_to_west, so the transmitter never overruns the buffer.

---
 rtl/pe_link_pkg.sv | 38 +++
 rtl/pe_link_fifo.sv | 86 ++++++++
 rtl/pe_west_rx.sv | 114 +++++++++++
 3 files changed

// File: rtl/pe_link_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pe_link_pkg
//  Description : Shared definitions for the PE mesh link (transmitter and
//                receiver tiles). Link word layout is {valid, last, payload};
//                the credit-return word carries a single pulse bit.
//  Revision    : 1.0  initial release
// ============================================================================
package pe_link_pkg;

  // Default link geometry and buffering.
  localparam int DEFAULT_WEST_WIDTH = 130;
  localparam int DEFAULT_FIFO_DEPTH = 4;
  localparam int DEFAULT_CNT_WIDTH  = 16;

  // Field positions for the default link width.
  localparam int LINK_VALID_BIT   = DEFAULT_WEST_WIDTH - 1;
  localparam int LINK_LAST_BIT    = DEFAULT_WEST_WIDTH - 2;
  localparam int LINK_PAYLOAD_MSB = DEFAULT_WEST_WIDTH - 3;

  // Credit pulse position in the return word.
  localparam int CREDIT_BIT = 0;

  // Field positions for an arbitrary link width.
  function automatic int link_valid_bit(input int width);
    return width - 1;
  endfunction

  function automatic int link_last_bit(input int width);
    return width - 2;
  endfunction

  function automatic int link_payload_msb(input int width);
    return width - 3;
  endfunction

endpackage : pe_link_pkg
`default_nettype wire

// File: rtl/pe_link_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pe_link_fifo
//  Description : Synchronous show-ahead FIFO. The head entry is always
//                visible on rd_data (zero when empty). A push into a full
//                FIFO is accepted only if a pop happens in the same cycle;
//                otherwise the word is dropped and 'drop' flags it.
//  Ports       : clk, reset (async, active-low)
//                push/push_data  - write request and word
//                pop             - advance head (ignored when empty)
//                rd_data         - head word
//                level           - occupancy 0..DEPTH
//                full/empty      - occupancy flags
//                drop            - push rejected this cycle
//  Revision    : 1.0  initial release
// ============================================================================
module pe_link_fifo
  import pe_link_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_d, wr_ptr_q;
  logic [AW-1:0]    rd_ptr_d, rd_ptr_q;
  logic [AW:0]      level_d, level_q;
  logic             pop_ok;
  logic             push_ok;

  always_comb begin
    empty   = (level_q == '0);
    full    = (level_q == (AW+1)'(DEPTH));
    pop_ok  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_ok = push & (~full | pop_ok);
    drop    = push & full & ~pop_ok;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    // Pointers wrap naturally because DEPTH is a power of two.
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase

    // Storage is not reset, so mask the head while empty.
    rd_data = empty ? '0 : mem_q[rd_ptr_q];
    level   = level_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule : pe_link_fifo
`default_nettype wire

// File: rtl/pe_west_rx.sv
`default_nettype none
// ============================================================================
//  Module      : pe_west_rx
//  Description : West-side mesh link receiver for a PE tile. Registers the
//                incoming link word, buffers valid words in a show-ahead
//                FIFO, presents them as a valid/ready stream, and returns a
//                one-cycle credit pulse upstream for every word consumed.
//  Ports       : clk, reset (async, active-low)
//                ap_start      - enables link capture
//                in_from_west  - link word {valid, last, payload}
//                out_to_west   - credit return, bit 0 pulses per pop
//                m_data/m_last/m_valid/m_ready - output stream
//                fifo_level    - buffer occupancy
//                pkt_count     - packets (last words) consumed, wrapping
//                overflow      - sticky, a word was dropped on a full FIFO
//  Revision    : 1.0  initial release
// ============================================================================
module pe_west_rx
  import pe_link_pkg::*;
#(
  parameter int WEST_WIDTH = DEFAULT_WEST_WIDTH,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ap_start,
  input  logic [WEST_WIDTH-1:0]         in_from_west,
  output logic [WEST_WIDTH-1:0]         out_to_west,
  output logic [WEST_WIDTH-3:0]         m_data,
  output logic                          m_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_WIDTH-1:0]          pkt_count,
  output logic                          overflow
);

  localparam int VALID_BIT   = link_valid_bit(WEST_WIDTH);
  localparam int LAST_BIT    = link_last_bit(WEST_WIDTH);
  localparam int PAYLOAD_MSB = link_payload_msb(WEST_WIDTH);
  localparam int ENTRY_W     = WEST_WIDTH - 1;  // {last, payload}

  logic [WEST_WIDTH-1:0] in_d, in_q;
  logic                  credit_d, credit_q;
  logic [CNT_WIDTH-1:0]  pkt_count_d, pkt_count_q;
  logic                  overflow_d, overflow_q;

  logic [ENTRY_W-1:0]    fifo_rd_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_drop;
  logic                  pop;
  logic                  unused_fifo_full;

  // Capture: only the valid bit is gated; payload/last are don't-care when idle.
  always_comb begin
    in_d            = in_from_west;
    in_d[VALID_BIT] = in_from_west[VALID_BIT] & ap_start;
  end

  pe_link_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (in_q[VALID_BIT]),
    .push_data (in_q[LAST_BIT:0]),
    .pop       (pop),
    .rd_data   (fifo_rd_data),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .drop      (fifo_drop)
  );

  // Full is implied by drop; kept on the FIFO interface for other users.
  assign unused_fifo_full = fifo_full;

  always_comb begin
    m_valid = ~fifo_empty;
    m_last  = fifo_rd_data[ENTRY_W-1];
    m_data  = fifo_rd_data[PAYLOAD_MSB:0];
    pop     = m_valid & m_ready;

    // Output side runs independently of ap_start.
    credit_d    = pop;
    pkt_count_d = pkt_count_q;
    if (pop && m_last) pkt_count_d = pkt_count_q + CNT_WIDTH'(1);
    overflow_d  = overflow_q | fifo_drop;

    out_to_west             = '0;
    out_to_west[CREDIT_BIT] = credit_q;
    pkt_count               = pkt_count_q;
    overflow                = overflow_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_q        <= '0;
      credit_q    <= 1'b0;
      pkt_count_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      in_q        <= in_d;
      credit_q    <= credit_d;
      pkt_count_q <= pkt_count_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule : pe_west_rx
`default_nettype wire
